// File: rtl/addsub_acc_pkg.sv
// rtl/addsub_acc_pkg.sv - shared state type and default sizes for the add/sub accumulator
package addsub_acc_pkg;

   localparam int DEF_WIDTH     = 3;
   localparam int DEF_ACC_WIDTH = 6;
   localparam int DEF_BURST     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_e;

endpackage

// File: rtl/addsub_acc_core.sv
// rtl/addsub_acc_core.sv - combinational adder/subtractor, b inverted by sub with carry-in = sub
module addsub_acc_core
   import addsub_acc_pkg::*;
#(
   parameter int W = DEF_ACC_WIDTH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W-1:0] b_x;

   // Invert b for subtract; carry-in of one completes the two's complement
   always_comb begin
      b_x          = b ^ {W{sub}};
      {carry, sum} = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, sub};
   end

endmodule

// File: rtl/addsub_accumulator.sv
// rtl/addsub_accumulator.sv - burst accumulator of add/sub beats; ADDSUB_ACC_SAT_EN selects saturation
module addsub_accumulator
   import addsub_acc_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int BURST     = DEF_BURST
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_ovf
);

   localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

   acc_state_e           state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [ACC_WIDTH-1:0] op_ext;
   logic [ACC_WIDTH-1:0] core_sum;
   logic                 core_carry;
   logic                 beat_ovf;
   logic [ACC_WIDTH-1:0] beat_result;
   logic                 accept;

   assign op_ext = ACC_WIDTH'(in_data);

   addsub_acc_core #(.W(ACC_WIDTH)) u_core (
      .a     (acc_q),
      .b     (op_ext),
      .sub   (in_sub),
      .sum   (core_sum),
      .carry (core_carry)
   );

   // Carry out on add or missing carry (borrow) on subtract flags this beat; optionally clamp
   always_comb begin
      beat_ovf    = in_sub ? ~core_carry : core_carry;
      beat_result = core_sum;
`ifdef ADDSUB_ACC_SAT_EN
      if (beat_ovf) begin
         beat_result = in_sub ? {ACC_WIDTH{1'b0}} : {ACC_WIDTH{1'b1}};
      end
`endif
   end

   // Handshake outputs decode registered state only; ready is held low while in reset
   always_comb begin
      in_ready  = rst_n && (state_q != HOLD);
      out_valid = (state_q == HOLD);
      out_sum   = acc_q;
      out_ovf   = ovf_q;
      accept    = in_valid && in_ready;
   end

   // Next-state: clear dominates, beats fold in until the burst completes, HOLD waits for the consumer
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_d = beat_result;
                  ovf_d = ovf_q | beat_ovf;
                  if (cnt_q == CNT_LAST) begin
                     state_d = HOLD;
                     cnt_d   = '0;
                  end else begin
                     state_d = ACCUM;
                     cnt_d   = cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, accumulator, sticky flag and beat counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
